// File: rtl/pc_seq_pkg.sv
// Shared definitions for the PC fetch sequencer.
// - state_e : fetch/execute FSM encoding
// - DEF_*   : default PC width, reset PC and fetch timeout used by the top-level parameters
package pc_seq_pkg;

  localparam int unsigned DEF_PC_W     = 32;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam int unsigned DEF_TIMEOUT  = 15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    EXEC   = 2'd2,
    HALTED = 2'd3
  } state_e;

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Instruction-memory fetch port.
// - imem_req  : fetch request, held until imem_ack
// - imem_addr : word address of the instruction being fetched
// - imem_ack  : memory returns the word this cycle
// The master modport is the sequencer; the slave modport is the instruction memory.
interface pc_fetch_sequencer_if
  import pc_seq_pkg::*;
#(
  parameter int unsigned PC_W = DEF_PC_W
);

  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack
  );

endinterface

// File: rtl/pc_fetch_sequencer_next_pc_adder.sv
// Next-PC arithmetic, purely combinational.
// - pc        : current program counter
// - br_imm    : signed word offset (two's complement)
// - pc_plus1  : pc + 1, wrapping modulo 2^PC_W
// - br_target : pc_plus1 + br_imm, wrapping modulo 2^PC_W
module next_pc_adder
  import pc_seq_pkg::*;
#(
  parameter int unsigned PC_W = DEF_PC_W
) (
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] br_imm,
  output logic [PC_W-1:0] pc_plus1,
  output logic [PC_W-1:0] br_target
);

  // Truncating adds: wrap-around in either direction is intentional, no overflow flag.
  assign pc_plus1  = pc + PC_W'(1);
  assign br_target = pc_plus1 + br_imm;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and fetch/execute sequencer.
// - clk, rst_n  : clock, asynchronous active-low reset
// - imem        : fetch port (req/addr out, ack in)
// - instr_valid : one-cycle pulse on the first EXEC cycle of each instruction
// - pc, pc_plus1: current PC and its wrapped successor
// - br_taken, br_imm, jmp, jmp_target, halt, stall : execute-stage controls, used only in EXEC
// - halted      : sticky stop flag; fetch_err : sticky fetch-timeout flag
module pc_fetch_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned     PC_W     = DEF_PC_W,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEF_RESET_PC),
  parameter int unsigned     TIMEOUT  = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pc_fetch_sequencer_if.master  imem,
  output logic                  instr_valid,
  output logic [PC_W-1:0]       pc,
  output logic [PC_W-1:0]       pc_plus1,
  input  logic                  br_taken,
  input  logic [PC_W-1:0]       br_imm,
  input  logic                  jmp,
  input  logic [PC_W-1:0]       jmp_target,
  input  logic                  stall,
  input  logic                  halt,
  output logic                  halted,
  output logic                  fetch_err
);

  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic            valid_q, valid_d;
  logic            halted_q, halted_d;
  logic            err_q, err_d;
  logic            imem_req;
  logic [PC_W-1:0] br_target;

  next_pc_adder #(
    .PC_W (PC_W)
  ) u_next_pc_adder (
    .pc        (pc_q),
    .br_imm    (br_imm),
    .pc_plus1  (pc_plus1),
    .br_target (br_target)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      wait_cnt_q <= '0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      wait_cnt_q <= wait_cnt_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    wait_cnt_d = wait_cnt_q;
    valid_d    = 1'b0;
    halted_d   = halted_q;
    err_d      = err_q;
    imem_req   = 1'b0;

    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        // Ack takes precedence over the timeout check in the same cycle.
        if (imem.imem_ack) begin
          valid_d    = 1'b1;
          wait_cnt_d = '0;
          state_d    = EXEC;
        end else if (wait_cnt_q == CntW'(TIMEOUT)) begin
          err_d    = 1'b1;
          halted_d = 1'b1;
          state_d  = HALTED;
        end else begin
          wait_cnt_d = wait_cnt_q + CntW'(1);
        end
      end
      EXEC: begin
        // Stall freezes everything; redirects are only looked at once it drops.
        if (!stall) begin
          if (halt) begin
            halted_d = 1'b1;
            state_d  = HALTED;
          end else begin
            if (jmp) begin
              pc_d = jmp_target;
            end else if (br_taken) begin
              pc_d = br_target;
            end else begin
              pc_d = pc_plus1;
            end
            state_d = FETCH;
          end
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
    endcase
  end

  assign imem.imem_req  = imem_req;
  assign imem.imem_addr = pc_q;
  assign instr_valid    = valid_q;
  assign pc             = pc_q;
  assign halted         = halted_q;
  assign fetch_err      = err_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
module tb_pc_fetch_sequencer;

  localparam int unsigned Timeout = 15;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus1;
  logic        br_taken;
  logic [31:0] br_imm;
  logic        jmp;
  logic [31:0] jmp_target;
  logic        stall;
  logic        halt;
  logic        halted;
  logic        fetch_err;

  pc_fetch_sequencer_if #(.PC_W(32)) imem_bus ();

  pc_fetch_sequencer #(
    .PC_W     (32),
    .RESET_PC (32'h0),
    .TIMEOUT  (Timeout)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (imem_bus.master),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus1    (pc_plus1),
    .br_taken    (br_taken),
    .br_imm      (br_imm),
    .jmp         (jmp),
    .jmp_target  (jmp_target),
    .stall       (stall),
    .halt        (halt),
    .halted      (halted),
    .fetch_err   (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [31:0] model_pc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_ctrl();
    br_taken   = 1'($urandom);
    jmp        = 1'($urandom);
    halt       = 1'($urandom);
    stall      = 1'($urandom);
    br_imm     = $urandom;
    jmp_target = $urandom;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imem_bus.imem_ack = 1'b0;
    randomize_ctrl();
    step();
    step();
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_pc_plus1", pc_plus1, 32'h1);
    check_eq("rst_req", {31'b0, imem_bus.imem_req}, 32'h0);
    check_eq("rst_valid", {31'b0, instr_valid}, 32'h0);
    check_eq("rst_flags", {30'b0, halted, fetch_err}, 32'h0);
    rst_n = 1'b1;
    // One idle cycle after release before the first fetch.
    check_eq("idle_req", {31'b0, imem_bus.imem_req}, 32'h0);
    model_pc = 32'h0;
  endtask

  // Waits for a request, then acks after `delay` unacknowledged cycles.
  task automatic do_fetch(input int delay);
    int i = 0;
    while (!imem_bus.imem_req && i < 8) begin
      step();
      i++;
    end
    check_eq("req_seen", {31'b0, imem_bus.imem_req}, 32'h1);
    check_eq("fetch_addr", imem_bus.imem_addr, model_pc);
    imem_bus.imem_ack = 1'b0;
    for (int k = 0; k < delay; k++) begin
      step();
      check_eq("req_hold", {31'b0, imem_bus.imem_req}, 32'h1);
      check_eq("valid_idle", {31'b0, instr_valid}, 32'h0);
    end
    imem_bus.imem_ack = 1'b1;
    step();
    imem_bus.imem_ack = 1'b0;
    check_eq("valid_pulse", {31'b0, instr_valid}, 32'h1);
    check_eq("exec_req", {31'b0, imem_bus.imem_req}, 32'h0);
    check_eq("pc_plus1", pc_plus1, model_pc + 32'd1);
  endtask

  // Runs `stalls` stalled cycles with junk controls, then applies the given controls.
  task automatic do_exec(input int stalls, input logic h, input logic j, input logic [31:0] jt,
                         input logic b, input logic [31:0] imm, output bit stopped);
    for (int k = 0; k < stalls; k++) begin
      randomize_ctrl();
      stall = 1'b1;
      step();
      check_eq("stall_valid", {31'b0, instr_valid}, 32'h0);
      check_eq("stall_pc", pc, model_pc);
      check_eq("stall_req", {31'b0, imem_bus.imem_req}, 32'h0);
    end
    stall = 1'b0;
    halt = h;
    jmp = j;
    jmp_target = jt;
    br_taken = b;
    br_imm = imm;
    if (!h) begin
      if (j) model_pc = jt;
      else if (b) model_pc = model_pc + 32'd1 + imm;
      else model_pc = model_pc + 32'd1;
    end
    step();
    randomize_ctrl();
    check_eq("exec_pc", pc, model_pc);
    stopped = h;
    if (h) begin
      check_eq("halt_flags", {30'b0, halted, fetch_err}, 32'h2);
      check_eq("halt_req", {31'b0, imem_bus.imem_req}, 32'h0);
    end else begin
      check_eq("next_req", {31'b0, imem_bus.imem_req}, 32'h1);
      check_eq("next_addr", imem_bus.imem_addr, model_pc);
      check_eq("next_valid", {31'b0, instr_valid}, 32'h0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit stp;
    int tmp;
    logic [31:0] imm;
    imem_bus.imem_ack = 1'b0;
    randomize_ctrl();
    do_reset();

    // Zero-wait sequential fetches 0..3, instr_valid every other cycle.
    for (int n = 0; n < 4; n++) begin
      do_fetch(0);
      do_exec(0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, stp);
    end
    check_eq("seq_end", imem_bus.imem_addr, 32'h4);

    // Branch backwards from 0x10.
    do_fetch(0);
    do_exec(0, 1'b0, 1'b1, 32'h10, 1'b0, 32'h0, stp);
    do_fetch(0);
    do_exec(0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFB, stp);
    check_eq("br_neg", imem_bus.imem_addr, 32'h0C);

    // Jump beats branch.
    do_fetch(0);
    do_exec(0, 1'b0, 1'b1, 32'h10, 1'b0, 32'h0, stp);
    do_fetch(0);
    do_exec(0, 1'b0, 1'b1, 32'h40, 1'b1, 32'h7, stp);
    check_eq("jmp_wins", imem_bus.imem_addr, 32'h40);

    // Stall for 3 cycles with toggling controls; branch applied at release only.
    do_fetch(0);
    do_exec(0, 1'b0, 1'b1, 32'h10, 1'b0, 32'h0, stp);
    do_fetch(1);
    do_exec(3, 1'b0, 1'b0, 32'h0, 1'b1, 32'h3, stp);
    check_eq("stall_br", imem_bus.imem_addr, 32'h14);

    // Sequential wrap at the top of the address space.
    do_fetch(0);
    do_exec(0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0, stp);
    do_fetch(0);
    do_exec(0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, stp);
    check_eq("wrap", imem_bus.imem_addr, 32'h0);

    // Ack arriving on the last allowed wait cycle still completes the fetch.
    do_fetch(Timeout);
    do_exec(0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, stp);

    // Randomized instruction stream.
    for (int n = 0; n < 80; n++) begin
      do_fetch(($urandom_range(0, 9) == 0) ? Timeout : int'($urandom_range(0, 2)));
      tmp = int'($urandom_range(0, 63)) - 32;
      imm = ($urandom_range(0, 3) == 0) ? $urandom : 32'(tmp);
      do_exec(int'($urandom_range(0, 2)), ($urandom_range(0, 19) == 0),
              ($urandom_range(0, 4) == 0), $urandom, 1'($urandom), imm, stp);
      if (stp) begin
        repeat (3) begin
          step();
          check_eq("halt_pc", pc, model_pc);
          check_eq("halt_hold", {30'b0, halted, imem_bus.imem_req}, 32'h2);
        end
        do_reset();
      end
    end

    // Fetch timeout: Timeout+1 unacknowledged fetch cycles trip the error.
    do_reset();
    step();
    check_eq("to_req", {31'b0, imem_bus.imem_req}, 32'h1);
    imem_bus.imem_ack = 1'b0;
    repeat (Timeout) step();
    check_eq("to_not_yet", {29'b0, imem_bus.imem_req, halted, fetch_err}, 32'h4);
    step();
    check_eq("to_flags", {30'b0, halted, fetch_err}, 32'h3);
    check_eq("to_req_off", {31'b0, imem_bus.imem_req}, 32'h0);
    imem_bus.imem_ack = 1'b1;
    step();
    imem_bus.imem_ack = 1'b0;
    check_eq("to_stays", {29'b0, imem_bus.imem_req, halted, fetch_err}, 32'h3);

    // Asynchronous reset mid-fetch, with an ack still in flight.
    do_reset();
    do_fetch(0);
    do_exec(0, 1'b0, 1'b1, 32'h55, 1'b0, 32'h0, stp);
    check_eq("pre_rst_addr", imem_bus.imem_addr, 32'h55);
    imem_bus.imem_ack = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_req", {31'b0, imem_bus.imem_req}, 32'h0);
    check_eq("arst_pc", pc, 32'h0);
    step();
    rst_n = 1'b1;
    check_eq("arst_idle", {31'b0, imem_bus.imem_req}, 32'h0);
    step();
    imem_bus.imem_ack = 1'b0;
    check_eq("refetch_req", {31'b0, imem_bus.imem_req}, 32'h1);
    check_eq("refetch_addr", imem_bus.imem_addr, 32'h0);
    check_eq("refetch_valid", {31'b0, instr_valid}, 32'h0);
    model_pc = 32'h0;
    do_fetch(0);
    do_exec(0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, stp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
